walk_phase_controller: RTL and testbench
========================================

WALK_PHASE_CONTROLLER -- requirements
Module: walk_phase_controller

Interface
REQ-001 The block SHALL expose parameter CLK_PER_SEC, default 100000000, meaning clk cycles per one-second tick (minimum 2).
REQ-002 The block SHALL expose parameter T_BASE, default 6, meaning base green duration in seconds (minimum 1).
REQ-003 The block SHALL expose parameter T_EXT, default 3, meaning walk and side-green extension duration in seconds (minimum 1).
REQ-004 The block SHALL expose parameter T_YEL, default 2, meaning yellow duration in seconds (minimum 1).
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 WalkReg_Reset  input  1  reset, asynchronous, active-high.
REQ-007 WalkReq  input  1  latched pedestrian request from the walk register, level.
REQ-008 Sensor  input  1  side-street vehicle present, synchronous level.
REQ-009 Main_Light  output  3  main-street lamps {R,Y,G}, one-hot.
REQ-010 Side_Light  output  3  side-street lamps {R,Y,G}, one-hot.
REQ-011 Walk_Lamp  output  1  pedestrian walk indication.
REQ-012 Walk_Clear  output  1  one-cycle pulse that clears the walk register.
REQ-013 State  output  3  encoded current state, for debug.

Function
REQ-014 States and State encodings SHALL be: MAIN_GRN=0, MAIN_YEL=1, WALK=2, SIDE_GRN=3, SIDE_EXT=4, SIDE_YEL=5; codes 6 and 7 SHALL go to MAIN_GRN on the next clk.
REQ-015 Timing SHALL use a prescaler (0..CLK_PER_SEC-1) and a seconds down-counter; both SHALL reload on every state entry, so a state of duration D lasts exactly D*CLK_PER_SEC cycles.
REQ-016 "Expiry" SHALL mean the last cycle of a state's duration; transitions SHALL occur on the clk edge that ends that cycle.
REQ-017 MAIN_GRN (duration T_BASE): at expiry, go to MAIN_YEL if WalkReq or Sensor is 1; otherwise rerun MAIN_GRN for a further T_BASE with outputs unchanged.
REQ-018 MAIN_YEL (duration T_YEL): at expiry, go to WALK if WalkReq=1, otherwise go to SIDE_GRN.
REQ-019 WALK (duration T_EXT): at expiry, go to SIDE_GRN if Sensor=1, otherwise go to MAIN_GRN.
REQ-020 SIDE_GRN (duration T_BASE): at expiry, go to SIDE_EXT if Sensor=1, otherwise go to SIDE_YEL.
REQ-021 SIDE_EXT (duration T_EXT): at expiry, go to SIDE_YEL; only one extension SHALL occur per side phase.
REQ-022 SIDE_YEL (duration T_YEL): at expiry, go to MAIN_GRN.
REQ-023 Lamps per state SHALL be:
- MAIN_GRN: Main=G, Side=R
- MAIN_YEL: Main=Y, Side=R
- WALK: Main=R, Side=R, Walk_Lamp=1
- SIDE_GRN and SIDE_EXT: Main=R, Side=G
- SIDE_YEL: Main=R, Side=Y
- Walk_Lamp SHALL be 0 in every state other than WALK.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-025 Walk_Clear SHALL be 1 for exactly the first cycle of WALK, i.e. the cycle after the MAIN_YEL->WALK edge, and 0 otherwise.
REQ-026 A WalkReq re-asserted during WALK (after the clear) SHALL stay pending and be served in the next cycle through MAIN_YEL; it SHALL NOT extend the current WALK.
REQ-027 WalkReq and Sensor both 1 at MAIN_YEL expiry: WALK SHALL take priority over SIDE_GRN.
REQ-028 Input changes between expiries SHALL have no effect; decisions SHALL sample inputs only in the expiry cycle.
REQ-029 Main_Light and Side_Light SHALL never both show G or Y in the same cycle.

Reset
REQ-030 While WalkReg_Reset=1, regardless of clk:
- state SHALL be MAIN_GRN
- prescaler SHALL be 0 and the seconds counter SHALL be T_BASE
- Main_Light SHALL be 001 and Side_Light SHALL be 100
- Walk_Lamp, Walk_Clear and State SHALL be 0
REQ-031 Reset asserted in mid-phase, including during WALK, SHALL abort the phase immediately with no Walk_Clear pulse; the walk register is cleared by the same reset.
REQ-032 After reset deassertion, the first MAIN_GRN SHALL last a full T_BASE*CLK_PER_SEC cycles.

Verification (CLK_PER_SEC=4, T_BASE=6, T_EXT=3, T_YEL=2)
REQ-033 Idle: WalkReq=0 and Sensor=0 for 100 cycles after reset -> Main_Light=001 and Side_Light=100 throughout, with State=0.
REQ-034 Walk only: WalkReq=1 from reset -> cycles 0-23 MAIN_GRN, cycles 24-31 MAIN_YEL, WALK entered at cycle 32 with Walk_Clear=1 only at cycle 32; drop WalkReq at cycle 33 -> MAIN_GRN at cycle 44.
REQ-035 Sensor held at 1, no walk request -> MAIN_GRN 24 cycles, MAIN_YEL 8, SIDE_GRN 24, SIDE_EXT 12, SIDE_YEL 8, then MAIN_GRN.
REQ-036 Simultaneous: WalkReq=1 and Sensor=1 -> sequence MAIN_YEL, WALK, SIDE_GRN; WalkReq re-pulsed mid-WALK -> the next main phase again passes through WALK.
REQ-037 Reset at cycle 34 (inside WALK) -> outputs take reset values asynchronously, before the next clk edge, with no Walk_Clear pulse.

Source files
------------

// File: rtl/walk_phase_controller.sv
// Pedestrian-aware main/side intersection phase controller.
// State is timed by a per-second prescaler and a seconds down-counter.
module walk_phase_controller #(
  parameter int CLK_PER_SEC = 100000000,
  parameter int T_BASE      = 6,
  parameter int T_EXT       = 3,
  parameter int T_YEL       = 2
) (
  input  logic       clk,
  input  logic       WalkReg_Reset,
  input  logic       WalkReq,
  input  logic       Sensor,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Lamp,
  output logic       Walk_Clear,
  output logic [2:0] State
);

  localparam int PW   = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam int TM1  = (T_BASE > T_EXT) ? T_BASE : T_EXT;
  localparam int TMAX = (TM1 > T_YEL) ? TM1 : T_YEL;
  localparam int SW   = $clog2(TMAX + 1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    WALK     = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_EXT = 3'd4,
    SIDE_YEL = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   sec_q, sec_d;
  logic [2:0]      main_q, main_d;
  logic [2:0]      side_q, side_d;
  logic            walk_q, walk_d;
  logic            clear_q, clear_d;
  logic            sec_tick;
  logic            expiry;
  logic            enter;

  function automatic logic [SW-1:0] dur(input state_t st);
    case (st)
      MAIN_YEL, SIDE_YEL: dur = SW'(T_YEL);
      WALK, SIDE_EXT:     dur = SW'(T_EXT);
      default:            dur = SW'(T_BASE);
    endcase
  endfunction

  assign sec_tick = (presc_q == PW'(CLK_PER_SEC - 1));
  assign expiry   = sec_tick && (sec_q == SW'(1));

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    case (state_q)
      MAIN_GRN: if (expiry) begin
        enter   = 1'b1;
        state_d = (WalkReq || Sensor) ? MAIN_YEL : MAIN_GRN;
      end
      MAIN_YEL: if (expiry) begin
        enter   = 1'b1;
        state_d = WalkReq ? WALK : SIDE_GRN;
      end
      WALK: if (expiry) begin
        enter   = 1'b1;
        state_d = Sensor ? SIDE_GRN : MAIN_GRN;
      end
      SIDE_GRN: if (expiry) begin
        enter   = 1'b1;
        state_d = Sensor ? SIDE_EXT : SIDE_YEL;
      end
      SIDE_EXT: if (expiry) begin
        enter   = 1'b1;
        state_d = SIDE_YEL;
      end
      SIDE_YEL: if (expiry) begin
        enter   = 1'b1;
        state_d = MAIN_GRN;
      end
      default: begin
        enter   = 1'b1;
        state_d = MAIN_GRN;
      end
    endcase

    // A rerun of MAIN_GRN counts as a fresh entry, so timers reload too.
    if (enter) begin
      presc_d = '0;
      sec_d   = dur(state_d);
    end else if (sec_tick) begin
      presc_d = '0;
      sec_d   = sec_q - SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
      sec_d   = sec_q;
    end

    // Lamps are decoded from the next state so the registered outputs track state_q.
    main_d  = LAMP_R;
    side_d  = LAMP_R;
    walk_d  = 1'b0;
    clear_d = (state_q == MAIN_YEL) && (state_d == WALK);
    case (state_d)
      MAIN_GRN: main_d = LAMP_G;
      MAIN_YEL: main_d = LAMP_Y;
      WALK:     walk_d = 1'b1;
      SIDE_GRN, SIDE_EXT: side_d = LAMP_G;
      SIDE_YEL: side_d = LAMP_Y;
      default: begin
        main_d = LAMP_G;
        side_d = LAMP_R;
      end
    endcase
  end

  always_ff @(posedge clk or posedge WalkReg_Reset) begin
    if (WalkReg_Reset) begin
      state_q <= MAIN_GRN;
      presc_q <= '0;
      sec_q   <= SW'(T_BASE);
      main_q  <= LAMP_G;
      side_q  <= LAMP_R;
      walk_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      main_q  <= main_d;
      side_q  <= side_d;
      walk_q  <= walk_d;
      clear_q <= clear_d;
    end
  end

  assign Main_Light = main_q;
  assign Side_Light = side_q;
  assign Walk_Lamp  = walk_q;
  assign Walk_Clear = clear_q;
  assign State      = state_q;

endmodule

// File: tb/tb_walk_phase_controller.sv
// Bench for walk_phase_controller: fixed vector table, hand-written corner
// sequences and a randomized run against a cycles-remaining reference model.
module tb_walk_phase_controller;

  localparam int CPS = 4;
  localparam int TB  = 6;
  localparam int TE  = 3;
  localparam int TY  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       sn;
  logic [2:0] main_l, side_l, state;
  logic       walk_l, walk_c;

  int checks = 0;
  int errors = 0;

  walk_phase_controller #(
    .CLK_PER_SEC(CPS),
    .T_BASE     (TB),
    .T_EXT      (TE),
    .T_YEL      (TY)
  ) dut (
    .clk          (clk),
    .WalkReg_Reset(rst),
    .WalkReq      (wr),
    .Sensor       (sn),
    .Main_Light   (main_l),
    .Side_Light   (side_l),
    .Walk_Lamp    (walk_l),
    .Walk_Clear   (walk_c),
    .State        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: state code plus cycles left in the current phase.
  int       m_state;
  int       m_rem;
  bit       m_clear;
  bit [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  bit [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
  int       sec_tab  [6] = '{TB, TY, TE, TB, TE, TY};

  function automatic int next_phase(int s, bit r, bit v);
    case (s)
      0:       return (r || v) ? 1 : 0;
      1:       return r ? 2 : 3;
      2:       return v ? 3 : 0;
      3:       return v ? 4 : 5;
      4:       return 5;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("state", int'(state), m_state);
    chk("main_light", int'(main_l), int'(main_tab[m_state]));
    chk("side_light", int'(side_l), int'(side_tab[m_state]));
    chk("walk_lamp", int'(walk_l), (m_state == 2) ? 1 : 0);
    chk("walk_clear", int'(walk_c), int'(m_clear));
    chk("no_conflict", int'((main_l[1:0] != 2'b00) && (side_l[1:0] != 2'b00)), 0);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rem   = TB * CPS;
    m_clear = 1'b0;
  endtask

  task automatic tick();
    int nxt;
    @(posedge clk);
    if (m_rem == 1) begin
      nxt     = next_phase(m_state, wr, sn);
      m_clear = (m_state == 1) && (nxt == 2);
      m_state = nxt;
      m_rem   = sec_tab[nxt] * CPS;
    end else begin
      m_rem   = m_rem - 1;
      m_clear = 1'b0;
    end
    #1;
    chk_outputs();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(bit r, bit v);
    @(negedge clk);
    rst = 1'b1;
    wr  = r;
    sn  = v;
    @(posedge clk);
    #1;
    model_reset();
    chk_outputs();
    chk("rst_state_held", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int       n;
    int       st;
    bit [2:0] main;
    bit [2:0] side;
  } vec_t;

  vec_t tv [10];

  initial begin
    // Sensor held high, no walk request: cumulative edges from reset release.
    tv[0] = '{23, 0, 3'b001, 3'b100};
    tv[1] = '{1,  1, 3'b010, 3'b100};
    tv[2] = '{7,  1, 3'b010, 3'b100};
    tv[3] = '{1,  3, 3'b100, 3'b001};
    tv[4] = '{23, 3, 3'b100, 3'b001};
    tv[5] = '{1,  4, 3'b100, 3'b001};
    tv[6] = '{11, 4, 3'b100, 3'b001};
    tv[7] = '{1,  5, 3'b100, 3'b010};
    tv[8] = '{7,  5, 3'b100, 3'b010};
    tv[9] = '{1,  0, 3'b001, 3'b100};

    rst = 1'b1;
    wr  = 1'b0;
    sn  = 1'b0;
    model_reset();
    #1;
    chk_outputs();

    // Idle for 100 cycles.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_state", int'(state), 0);
    end

    do_reset(1'b0, 1'b1);
    foreach (tv[i]) begin
      run(tv[i].n);
      chk("vec_state", int'(state), tv[i].st);
      chk("vec_main", int'(main_l), int'(tv[i].main));
      chk("vec_side", int'(side_l), int'(tv[i].side));
    end

    // Walk only: WALK at cycle 32, clear at 32 only, back to MAIN_GRN at 44.
    do_reset(1'b1, 1'b0);
    run(24);
    chk("walk_myel_24", int'(state), 1);
    run(8);
    chk("walk_enter_32", int'(state), 2);
    chk("walk_clear_32", int'(walk_c), 1);
    run(1);
    chk("walk_clear_33", int'(walk_c), 0);
    wr = 1'b0;
    run(10);
    chk("walk_43", int'(state), 2);
    run(1);
    chk("walk_exit_44", int'(state), 0);

    // Reset inside WALK at cycle 34 takes effect before the next edge.
    do_reset(1'b1, 1'b0);
    run(34);
    chk("pre_rst_walk", int'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_outputs();
    @(negedge clk);
    rst = 1'b0;
    wr  = 1'b0;
    run(24);

    // Walk and sensor together; walk re-requested mid-WALK.
    do_reset(1'b1, 1'b1);
    run(32);
    chk("sim_walk_32", int'(state), 2);
    run(1);
    wr = 1'b0;
    run(5);
    wr = 1'b1;
    run(6);
    chk("sim_side_44", int'(state), 3);
    run(44);
    chk("sim_main_88", int'(state), 0);
    run(32);
    chk("sim_walk_120", int'(state), 2);
    chk("sim_clear_120", int'(walk_c), 1);

    // Randomized inputs against the model.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      sn = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
